// File: rtl/rx_port_scheduler_pkg.sv
// Shared definitions for the receive-port scheduler and the rr_pick arbiter.
//   state_e    : scheduler FSM encoding (IDLE/RECV/DONE)
//   DATA_W_DEF : default message width
//   ptr_w()    : index width for an n-entry requester vector (min 1 bit)
package rx_port_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int DATA_W_DEF = 32;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rx_port_scheduler_rr_pick.sv
// rr_pick: combinational rotating-priority select.
// Searches req upward, with wrap, starting at last_ptr+1. Returns the first
// set index. Shared by other arbiters of single-owner resources.
//   req      in  NUM_REQ : request vector
//   last_ptr in  PTR_W   : most recently served index (lowest priority)
//   any      out 1       : at least one request set
//   idx      out PTR_W   : selected index (0 when any=0)
module rr_pick
  import rx_port_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = ptr_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   last_ptr,
  output logic               any,
  output logic [PTR_W-1:0]   idx
);

  logic [PTR_W-1:0] cand;

  assign any = |req;

  // Walk from the farthest candidate back to the nearest. The last hit
  // written is the closest to last_ptr+1, so no found flag is needed.
  always_comb begin
    idx  = '0;
    cand = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = PTR_W'((int'(last_ptr) + i) % NUM_REQ);
      if (req[cand]) idx = cand;
    end
  end

endmodule

// File: rtl/rx_port_scheduler.sv
// rx_port_scheduler: shares one valid/ready receive port among NUM_REQ
// stalled units. It grants round-robin and captures one beat per grant.
// It returns the beat with a one-cycle done pulse to the owner.
//   clk_i, reset_i (async, active-high)
//   req_i     in  NUM_REQ : level requests, held until own done or abort
//   grant_o   out NUM_REQ : one-hot owner, high in RECV and DONE
//   done_o    out NUM_REQ : one-cycle pulse, message_o valid
//   message_o out DATA_W  : last captured beat
//   timeout_o out 1       : one-cycle pulse when a grant expires
//   valid_i, message_i, ready_o : inbound port handshake
// Every output decodes from registers only. Nothing on valid_i or req_i
// reaches an output in the same cycle.
module rx_port_scheduler
  import rx_port_scheduler_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [NUM_REQ-1:0] done_o,
  output logic [DATA_W-1:0]  message_o,
  output logic               timeout_o,
  input  logic               valid_i,
  input  logic [DATA_W-1:0]  message_i,
  output logic               ready_o
);

  localparam int PTR_W = ptr_w(NUM_REQ);
  // The counter holds 0..TIMEOUT_CYC-1.
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_e             state;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   last_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  msg_q;
  logic               tmo_q;
  logic               pick_any;
  logic [PTR_W-1:0]   pick_idx;
  logic [NUM_REQ-1:0] owner_oh;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req      (req_i),
    .last_ptr (last_ptr),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state    <= ST_IDLE;
      owner    <= '0;
      last_ptr <= PTR_W'(NUM_REQ - 1);   // requester 0 wins first
      cnt      <= '0;
      msg_q    <= '0;
      tmo_q    <= 1'b0;
    end else begin
      tmo_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (pick_any) begin
            owner <= pick_idx;
            state <= ST_RECV;
          end
        end
        ST_RECV: begin
          // A beat beats a dropped request or an expiry in the same cycle.
          // An abort coinciding with expiry is a plain abort. The owner left
          // on its own, so it keeps its priority and no timeout is flagged.
          if (valid_i) begin
            msg_q    <= message_i;
            last_ptr <= owner;
            state    <= ST_DONE;
          end else if (!req_i[owner]) begin
            state <= ST_IDLE;
          end else if (cnt == CNT_LAST) begin
            tmo_q    <= 1'b1;
            last_ptr <= owner;         // stalled owner drops to lowest priority
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
  end

  assign ready_o   = (state == ST_RECV);
  assign grant_o   = (state != ST_IDLE) ? owner_oh : '0;
  assign done_o    = (state == ST_DONE) ? owner_oh : '0;
  assign timeout_o = tmo_q;
  assign message_o = msg_q;

endmodule

// File: tb/tb_rx_port_scheduler.sv
// Directed bench for rx_port_scheduler (NUM_REQ=4, TIMEOUT_CYC=4).
// Each table row holds two things. First, the outputs expected at a falling
// edge, which come from earlier rows. Second, the inputs to drive for the
// next rising edge.
module tb_rx_port_scheduler;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [3:0]  req_i;
  logic [3:0]  grant_o, done_o;
  logic [31:0] message_o, message_i;
  logic        timeout_o, valid_i, ready_o;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  rx_port_scheduler #(
    .NUM_REQ     (4),
    .DATA_W      (32),
    .TIMEOUT_CYC (4)
  ) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_i     (req_i),
    .grant_o   (grant_o),
    .done_o    (done_o),
    .message_o (message_o),
    .timeout_o (timeout_o),
    .valid_i   (valid_i),
    .message_i (message_i),
    .ready_o   (ready_o)
  );

  typedef struct {
    logic        e_ready;
    logic [3:0]  e_grant;
    logic [3:0]  e_done;
    logic [31:0] e_msg;
    logic        e_tmo;
    logic [3:0]  req;
    logic        valid;
    logic [31:0] msg;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic er, input logic [3:0] eg, input logic [3:0] ed,
                              input logic [31:0] em, input logic et,
                              input logic [3:0] rq, input logic v, input logic [31:0] m);
    vec_t t;
    t.e_ready = er; t.e_grant = eg; t.e_done = ed; t.e_msg = em; t.e_tmo = et;
    t.req = rq; t.valid = v; t.msg = m;
    return t;
  endfunction

  task automatic chk(input string nm, input logic er, input logic [3:0] eg,
                     input logic [3:0] ed, input logic [31:0] em, input logic et);
    n_chk++;
    if ({ready_o, grant_o, done_o, message_o, timeout_o} !== {er, eg, ed, em, et}) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b gnt=%b done=%b msg=%h tmo=%b, want rdy=%b gnt=%b done=%b msg=%h tmo=%b",
               nm, ready_o, grant_o, done_o, message_o, timeout_o, er, eg, ed, em, et);
    end
  endtask

  initial begin
    reset_i = 1'b1; req_i = '0; valid_i = 1'b0; message_i = '0;
    repeat (2) @(negedge clk_i);
    chk("reset", 0, 4'b0000, 4'b0000, 32'h0, 0);
    reset_i = 1'b0;

    //            rdy grant    done     msg           tmo  req      v  msg_in
    // fairness: all four request, each drops after its own done
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h00000000, 0, 4'b1111, 1, 32'h11111111));
    vecs.push_back(mk(1, 4'b0001, 4'b0000, 32'h00000000, 0, 4'b1111, 1, 32'h11111111));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 32'h11111111, 0, 4'b1110, 1, 32'h22222222));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h11111111, 0, 4'b1110, 1, 32'h22222222));
    vecs.push_back(mk(1, 4'b0010, 4'b0000, 32'h11111111, 0, 4'b1110, 1, 32'h22222222));
    vecs.push_back(mk(0, 4'b0010, 4'b0010, 32'h22222222, 0, 4'b1100, 1, 32'h33333333));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h22222222, 0, 4'b1100, 1, 32'h33333333));
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 32'h22222222, 0, 4'b1100, 1, 32'h33333333));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 32'h33333333, 0, 4'b1000, 1, 32'h44444444));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h33333333, 0, 4'b1000, 1, 32'h44444444));
    vecs.push_back(mk(1, 4'b1000, 4'b0000, 32'h33333333, 0, 4'b1000, 1, 32'h44444444));
    vecs.push_back(mk(0, 4'b1000, 4'b1000, 32'h44444444, 0, 4'b0000, 0, 32'h0));
    // wrap-around: last owner 3, req 1001 -> 0 then 3
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h44444444, 0, 4'b1001, 1, 32'h55555555));
    vecs.push_back(mk(1, 4'b0001, 4'b0000, 32'h44444444, 0, 4'b1001, 1, 32'h55555555));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 32'h55555555, 0, 4'b1000, 1, 32'h66666666));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h55555555, 0, 4'b1000, 1, 32'h66666666));
    vecs.push_back(mk(1, 4'b1000, 4'b0000, 32'h55555555, 0, 4'b1000, 1, 32'h66666666));
    vecs.push_back(mk(0, 4'b1000, 4'b1000, 32'h66666666, 0, 4'b0000, 0, 32'h0));
    // single requester: valid held while idle must not capture early
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h66666666, 0, 4'b0001, 1, 32'hDEADBEEF));
    vecs.push_back(mk(1, 4'b0001, 4'b0000, 32'h66666666, 0, 4'b0001, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 32'hDEADBEEF, 0, 4'b0000, 0, 32'h0));
    // abort: owner 2 drops with no beat; last_ptr stays 0 so 2 beats 3 next
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'hDEADBEEF, 0, 4'b0100, 0, 32'h0));
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 32'hDEADBEEF, 0, 4'b0000, 0, 32'h0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'hDEADBEEF, 0, 4'b1100, 0, 32'h0));
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 32'hDEADBEEF, 0, 4'b1100, 1, 32'h77777777));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 32'h77777777, 0, 4'b0000, 0, 32'h0));
    // timeout: owner 1 stalls 4 RECV cycles, then 0 goes ahead of it
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h77777777, 0, 4'b0010, 0, 32'h0));
    vecs.push_back(mk(1, 4'b0010, 4'b0000, 32'h77777777, 0, 4'b0011, 0, 32'h0));
    vecs.push_back(mk(1, 4'b0010, 4'b0000, 32'h77777777, 0, 4'b0011, 0, 32'h0));
    vecs.push_back(mk(1, 4'b0010, 4'b0000, 32'h77777777, 0, 4'b0011, 0, 32'h0));
    vecs.push_back(mk(1, 4'b0010, 4'b0000, 32'h77777777, 0, 4'b0011, 0, 32'h0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h77777777, 1, 4'b0011, 0, 32'h0));
    vecs.push_back(mk(1, 4'b0001, 4'b0000, 32'h77777777, 0, 4'b0011, 1, 32'h88888888));
    vecs.push_back(mk(0, 4'b0001, 4'b0001, 32'h88888888, 0, 4'b0010, 1, 32'h99999999));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h88888888, 0, 4'b0010, 1, 32'h99999999));
    vecs.push_back(mk(1, 4'b0010, 4'b0000, 32'h88888888, 0, 4'b0010, 1, 32'h99999999));
    vecs.push_back(mk(0, 4'b0010, 4'b0010, 32'h99999999, 0, 4'b0000, 0, 32'h0));
    // beat and dropped request in the same cycle: beat is delivered
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'h99999999, 0, 4'b0100, 0, 32'h0));
    vecs.push_back(mk(1, 4'b0100, 4'b0000, 32'h99999999, 0, 4'b0000, 1, 32'hAAAAAAAA));
    vecs.push_back(mk(0, 4'b0100, 4'b0100, 32'hAAAAAAAA, 0, 4'b0000, 0, 32'h0));
    vecs.push_back(mk(0, 4'b0000, 4'b0000, 32'hAAAAAAAA, 0, 4'b0000, 0, 32'h0));

    foreach (vecs[k]) begin
      chk($sformatf("vec%0d", k), vecs[k].e_ready, vecs[k].e_grant, vecs[k].e_done,
          vecs[k].e_msg, vecs[k].e_tmo);
      req_i = vecs[k].req; valid_i = vecs[k].valid; message_i = vecs[k].msg;
      @(negedge clk_i);
    end

    // async reset between edges while in RECV with a beat on offer
    req_i = 4'b0100; valid_i = 1'b0;
    @(negedge clk_i);
    chk("rst_pre", 1, 4'b0100, 4'b0000, 32'hAAAAAAAA, 0);
    valid_i = 1'b1; message_i = 32'hBBBBBBBB;
    #2 reset_i = 1'b1;
    #1 chk("rst_async", 0, 4'b0000, 4'b0000, 32'h0, 0);
    @(negedge clk_i);
    chk("rst_held", 0, 4'b0000, 4'b0000, 32'h0, 0);
    reset_i = 1'b0; req_i = 4'b1001; valid_i = 1'b0;
    @(negedge clk_i);
    chk("rst_prio", 1, 4'b0001, 4'b0000, 32'h0, 0);
    req_i = 4'b0000;
    @(negedge clk_i);
    chk("rst_abort", 0, 4'b0000, 4'b0000, 32'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_port_scheduler.md
# rx_port_scheduler

Shares one 32-bit valid/ready receive port between `NUM_REQ` processor units that stall until their message arrives. Requesters raise a level request; the scheduler grants them one at a time in round-robin order, opens the port (`ready_o`), captures exactly one beat for the granted requester and returns it with a one-cycle done pulse. It sits between the inbound message source and the per-unit stall logic.

## Interface
- `NUM_REQ`, 4, number of requesters (2..16)
- `DATA_W`, 32, message width
- `TIMEOUT_CYC`, 255, cycles in RECV without a beat before abandoning the grant (≥1)

- `clk_i` in 1: clock
- `reset_i` in 1: reset, asynchronous, active-high
- `req_i` in NUM_REQ: per-requester level request; hold until own `done_o` or abort
- `grant_o` out NUM_REQ: one-hot owner of the port, high throughout RECV and DONE
- `done_o` out NUM_REQ: one-cycle pulse to owner, message available
- `message_o` out DATA_W: last captured message, held until next capture
- `timeout_o` out 1: one-cycle pulse when a grant expires
- `valid_i` in 1: source has a beat on `message_i`
- `message_i` in DATA_W: inbound message
- `ready_o` out 1: port open; a beat transfers when `valid_i && ready_o`

## Operation
- State machine: IDLE → RECV → DONE → IDLE; RECV → IDLE on abort or timeout.
- IDLE:
  - If any `req_i` is set, select the first set bit searching upward, with wrap, from `last_ptr+1`.
  - Register the selection as `owner` and enter RECV.
  - With no request, stay in IDLE.
- RECV:
  - `ready_o`=1 and `grant_o[owner]`=1; the timeout counter increments each cycle.
  - On a beat: capture `message_i` into `message_o`, set `last_ptr`=`owner`, enter DONE.
  - Abort: `req_i[owner]`=0 with no beat this cycle. Go to IDLE with no done, and leave `last_ptr` unchanged.
  - Beat and dropped request in the same cycle: the beat wins and the message is delivered.
  - Timeout: counter reaches `TIMEOUT_CYC-1` with no beat. Pulse `timeout_o`, set `last_ptr`=`owner` (the stalled owner loses priority), go to IDLE.
- DONE:
  - `done_o[owner]`=1 for exactly this cycle and `ready_o`=0; return to IDLE.
  - The requester must drop `req_i` here. If it is still high, it is treated as a new request.
- Reset: every output is 0. State=IDLE, `last_ptr`=NUM_REQ-1 (requester 0 has first priority), counter=0, `message_o`=0.
- Reset mid-transfer: the in-flight beat is discarded and no done is issued.

## Timing
- All outputs are registered or decoded from registered state only. There is no combinational path from `valid_i` or `req_i` to any output.
- Request sampled in IDLE at cycle N gives `ready_o`, `grant_o` high at N+1.
- Beat at cycle M gives `done_o` and the new `message_o` at M+1; `ready_o` is low at M+1.
- Minimum request-to-done latency: 2 cycles. Peak throughput: 1 beat per 3 cycles.
- Timeout: `timeout_o` is high in the cycle after the `TIMEOUT_CYC`-th RECV cycle without a beat; `ready_o` is low that same cycle.
- `valid_i` while `ready_o`=0 is ignored; the source holds the beat.

## Structure
- Shared package:
  - state enum (IDLE/RECV/DONE, 2-bit)
  - `PTR_W`=$clog2(NUM_REQ) helper
  - default `DATA_W` constant
- Sub-module `rr_pick`: combinational rotating-priority select.
  - Inputs: `req` vector, `last_ptr`.
  - Outputs: `any`, `idx`.
  - Reused by other shared-resource arbiters.
- Top level holds the FSM, owner/pointer registers, timeout counter and message register.

## Test plan
- Single requester: `req_i`=0001, `valid_i`=1 with 0xDEADBEEF → `ready_o` at +1, `done_o`=0001 and `message_o`=0xDEADBEEF at +2, then back to IDLE.
- Fairness: `req_i`=1111 held, each requester dropping its own request after its done, `valid_i` always 1 → done order 0,1,2,3 with one done every 3 cycles.
- Wrap-around: after owner 3, `req_i`=1001 → requester 0 granted next, then 3.
- Abort: grant to 2, `valid_i`=0, drop `req_i[2]` → IDLE next cycle, no done, next grant order unchanged.
- Timeout: `TIMEOUT_CYC`=4, grant to 1, `valid_i`=0 → `timeout_o` pulse 4 cycles after `ready_o` rises; with `req_i`=0011 still set, requester 0 is granted next.
- Async reset asserted mid-RECV between clock edges → all outputs 0 immediately; after release, requester 0 has first priority.
